// File: rtl/writeback_unit_if.sv
// Handshake and register-file write bundle between the producers and the writeback unit.
interface writeback_unit_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              Reg_Write;
  logic [ADDR_W-1:0] Reg_address3;
  logic [DATA_W-1:0] Reg_input_data;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, Reg_Write, Reg_address3, Reg_input_data, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, Reg_Write, Reg_address3, Reg_input_data, fifo_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges 1-cycle ALU results with FIFO-buffered loads onto the register-file write port (registered).
// Define WB_BYPASS_EN to let a load skip the empty FIFO when the ALU is not writing.
module writeback_unit #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            CLK,
  input  logic            Reset,
  writeback_unit_if.slave wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] rd_mem_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] dat_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fifo_empty, alu_fire, push, pop;

  assign fifo_empty   = (count_q == '0);
  assign wb.mem_ready = (count_q < DEPTH_C);
  assign wb.alu_ready = !((starve_q == STV_LIM) && !fifo_empty);
  assign alu_fire     = wb.alu_valid && wb.alu_ready;
  assign pop          = !alu_fire && !fifo_empty;

`ifdef WB_BYPASS_EN
  logic bypass;
  assign bypass = !alu_fire && fifo_empty && wb.mem_valid;
  assign push   = wb.mem_valid && wb.mem_ready && !bypass;
`else
  assign push   = wb.mem_valid && wb.mem_ready;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Saturation at the limit drops alu_ready, which forces the next cycle to pop.
    if (pop || fifo_empty)                       starve_d = '0;
    else if (alu_fire && (starve_q != STV_LIM))  starve_d = starve_q + 1'b1;

    if (alu_fire) begin
      wr_d   = 1'b1;
      addr_d = wb.alu_rd;
      data_d = wb.alu_data;
    end else if (pop) begin
      wr_d   = 1'b1;
      addr_d = rd_mem_q[rd_ptr_q];
      data_d = dat_mem_q[rd_ptr_q];
    end
`ifdef WB_BYPASS_EN
    else if (bypass) begin
      wr_d   = 1'b1;
      addr_d = wb.mem_rd;
      data_d = wb.mem_data;
    end
`endif
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]  <= wb.mem_rd;
      dat_mem_q[wr_ptr_q] <= wb.mem_data;
    end
  end

  assign wb.Reg_Write      = wr_q;
  assign wb.Reg_address3   = addr_q;
  assign wb.Reg_input_data = data_q;
  assign wb.fifo_count     = count_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_writeback_unit;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 3;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  writeback_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) wb();

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .wb   (wb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending loads and a count of consecutive ALU wins.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
  } ld_t;

  ld_t               q[$];
  ld_t               head;
  int                m_starve;
  bit                e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  bit                m_arv, m_mrv, m_afire, m_pop, m_byp;

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      q.delete();
      m_starve = 0;
      e_wr     = 0;
      e_addr   = '0;
      e_data   = '0;
    end else begin
      m_arv   = !(m_starve == LIMIT && q.size() != 0);
      m_mrv   = q.size() < DEPTH;
      m_afire = wb.alu_valid && m_arv;
      m_pop   = !m_afire && q.size() != 0;
      m_byp   = 0;
`ifdef WB_BYPASS_EN
      m_byp   = !m_afire && q.size() == 0 && wb.mem_valid;
`endif
      if (m_pop || q.size() == 0) m_starve = 0;
      else if (m_afire && m_starve < LIMIT) m_starve++;

      if (m_afire) begin
        e_wr = 1; e_addr = wb.alu_rd; e_data = wb.alu_data;
      end else if (m_pop) begin
        head = q.pop_front();
        e_wr = 1; e_addr = head.rd; e_data = head.d;
      end else if (m_byp) begin
        e_wr = 1; e_addr = wb.mem_rd; e_data = wb.mem_data;
      end else begin
        e_wr = 0;
      end
      if (wb.mem_valid && m_mrv && !m_byp) q.push_back({wb.mem_rd, wb.mem_data});
    end
  end

  bit chk_en = 0;
  always @(negedge CLK) begin
    if (chk_en && Reset) begin
      check("m_reg_write", 32'(wb.Reg_Write), 32'(e_wr));
      check("m_reg_addr",  32'(wb.Reg_address3), 32'(e_addr));
      check("m_reg_data",  32'(wb.Reg_input_data), 32'(e_data));
      check("m_fifo_count", 32'(wb.fifo_count), 32'(q.size()));
      check("m_mem_ready", 32'(wb.mem_ready), 32'(q.size() < DEPTH));
      check("m_alu_ready", 32'(wb.alu_ready), 32'(!(m_starve == LIMIT && q.size() != 0)));
    end
  end

  task automatic drive(input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input bit mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
    wb.alu_valid = av; wb.alu_rd = ar; wb.alu_data = ad;
    wb.mem_valid = mv; wb.mem_rd = mr; wb.mem_data = md;
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0, '0);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(negedge CLK);
    Reset  = 1'b1;
    chk_en = 1;
    @(negedge CLK);
    check("rst_count", 32'(wb.fifo_count), 0);
    check("rst_mem_ready", 32'(wb.mem_ready), 1);
    check("rst_alu_ready", 32'(wb.alu_ready), 1);
    check("rst_reg_write", 32'(wb.Reg_Write), 0);

    // Single ALU op
    drive(1, 3'd5, 16'hBEEF, 0, '0, '0);
    @(negedge CLK);
    drive(0, '0, '0, 0, '0, '0);
    check("alu_wr", 32'(wb.Reg_Write), 1);
    check("alu_addr", 32'(wb.Reg_address3), 5);
    check("alu_data", 32'(wb.Reg_input_data), 32'h BEEF);
    @(negedge CLK);
    check("alu_wr_after", 32'(wb.Reg_Write), 0);
    check("alu_hold_addr", 32'(wb.Reg_address3), 5);

    // Single load with ALU idle
    drive(0, '0, '0, 1, 3'd2, 16'h1234);
    @(negedge CLK);
    drive(0, '0, '0, 0, '0, '0);
`ifdef WB_BYPASS_EN
    check("ld_byp_wr", 32'(wb.Reg_Write), 1);
    check("ld_byp_addr", 32'(wb.Reg_address3), 2);
    check("ld_byp_data", 32'(wb.Reg_input_data), 32'h1234);
    check("ld_byp_count", 32'(wb.fifo_count), 0);
`else
    check("ld_n1_wr", 32'(wb.Reg_Write), 0);
    check("ld_n1_count", 32'(wb.fifo_count), 1);
    @(negedge CLK);
    check("ld_n2_wr", 32'(wb.Reg_Write), 1);
    check("ld_n2_addr", 32'(wb.Reg_address3), 2);
    check("ld_n2_data", 32'(wb.Reg_input_data), 32'h1234);
    check("ld_n2_count", 32'(wb.fifo_count), 0);
`endif
    idle(2);

    // Four loads under continuous ALU traffic, then a pop cycle against a full FIFO
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 16'hA000 + 16'(i), 1, 3'(4 + i), 16'h4000 + 16'(i));
      @(negedge CLK);
    end
    check("full_mem_ready", 32'(wb.mem_ready), 0);
    check("full_alu_ready", 32'(wb.alu_ready), 0);
    check("full_count", 32'(wb.fifo_count), 4);
    drive(1, 3'd1, 16'hA004, 1, 3'd0, 16'h4004);
    @(negedge CLK);
    check("refuse_count", 32'(wb.fifo_count), 3);
    check("refuse_pop_data", 32'(wb.Reg_input_data), 32'h4000);
    check("refuse_mem_ready", 32'(wb.mem_ready), 1);
    @(negedge CLK);
    check("retry_count", 32'(wb.fifo_count), 4);
    check("retry_alu_data", 32'(wb.Reg_input_data), 32'hA004);
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'd3, 16'hB000 + 16'(i), 0, '0, '0);
      @(negedge CLK);
    end
    idle(6);
    check("drain_count", 32'(wb.fifo_count), 0);

    // Build count 3, then steady push/pop pairs with the ALU idle
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 16'hC000 + 16'(i), 1, 3'(i), 16'h5000 + 16'(i));
      @(negedge CLK);
    end
    check("pp_pre_count", 32'(wb.fifo_count), 3);
    for (int i = 0; i < 7; i++) begin
      drive(0, '0, '0, 1, 3'(i), 16'h6000 + 16'(i));
      @(negedge CLK);
      if (i == 0) begin
        check("pp_first_count", 32'(wb.fifo_count), 3);
        check("pp_first_data", 32'(wb.Reg_input_data), 32'h5000);
      end
    end
    check("pp_wrap_count", 32'(wb.fifo_count), 3);
    check("pp_wrap_data", 32'(wb.Reg_input_data), 32'h6003);
    idle(5);

    // Mid-run reset with three loads queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd6, 16'hD000 + 16'(i), 1, 3'(i), 16'h7000 + 16'(i));
      @(negedge CLK);
    end
    check("mrst_pre_count", 32'(wb.fifo_count), 3);
    drive(0, '0, '0, 0, '0, '0);
    #2 Reset = 1'b0;
    #1;
    check("mrst_count", 32'(wb.fifo_count), 0);
    check("mrst_wr", 32'(wb.Reg_Write), 0);
    check("mrst_addr", 32'(wb.Reg_address3), 0);
    check("mrst_data", 32'(wb.Reg_input_data), 0);
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("mrst_no_stale_wr", 32'(wb.Reg_Write), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom),
            $urandom_range(0, 99) < 50, 3'($urandom), 16'($urandom));
      @(negedge CLK);
      if (i == 1500) begin
        drive(0, '0, '0, 0, '0, '0);
        #2 Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
      end
    end
    idle(8);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
